// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the LCD request arbiter
package lcd_pkg;

   typedef enum logic [1:0] {
      CMD_CHAR   = 2'b00,
      CMD_CURSOR = 2'b01,
      CMD_CLEAR  = 2'b10,
      CMD_RSVD   = 2'b11
   } lcd_cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_GUARD    = 2'd2,
      ST_WAIT_RDY = 2'd3
   } arb_state_e;

   localparam logic [4:0] LCD_LINE2_POS = 5'd16;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with eligibility mask
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] mask,
   input  logic       update,
   output logic       gnt_vld,
   output logic       gnt_idx
);

   logic       last_grant;
   logic [1:0] elig;

   assign elig    = req & mask;
   assign gnt_vld = |elig;

   // On a tie the requester that did not win last time takes the grant.
   always_comb begin
      gnt_idx = 1'b0;
      case (elig)
         2'b01:   gnt_idx = 1'b0;
         2'b10:   gnt_idx = 1'b1;
         2'b11:   gnt_idx = ~last_grant;
         default: gnt_idx = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant <= 1'b1;
      else if (update && gnt_vld)
         last_grant <= gnt_idx;
   end

endmodule

// File: rtl/lcd_request_arbiter.sv
// rtl/lcd_request_arbiter.sv - shares lcd_display between two requesters
// Optional WAIT_RDY timeout with sticky error: define LCD_ARB_TIMEOUT_EN.
module lcd_request_arbiter
   import lcd_pkg::*;
#(
   parameter int GUARD_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [1:0]  req_lock,
   input  logic [3:0]  req_cmd,
   input  logic [15:0] req_data,
   output logic [7:0]  lcd_char,
   output logic        lcd_char_write,
   output logic [4:0]  lcd_cursor_pos,
   output logic        lcd_cursor_set,
   output logic        lcd_clear,
   input  logic        lcd_ready,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        error
);

   if (GUARD_CYCLES < 1 || GUARD_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("lcd_request_arbiter: parameter out of range");
   end

   arb_state_e state, state_n;
   lcd_cmd_e   cmd_q, cmd_w;
   logic [3:0] gcnt;
   logic [7:0] data_w;
   logic       win, win_q, gnt_vld, take;
   logic       lock_vld, lock_owner, lock_active;
   logic       timeout_hit;

   // A lock only counts while its owner keeps req_lock high.
   assign lock_active = lock_vld && req_lock[lock_owner];
   assign take        = (state == ST_IDLE) && lcd_ready && gnt_vld;
   assign cmd_w       = lcd_cmd_e'(win ? req_cmd[3:2] : req_cmd[1:0]);
   assign data_w      = win ? req_data[15:8] : req_data[7:0];

   rr_arbiter2 u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .mask    (lock_active ? onehot2(lock_owner) : 2'b11),
      .update  (take),
      .gnt_vld (gnt_vld),
      .gnt_idx (win)
   );

   always_comb begin
      state_n        = state;
      req_ready      = 2'b00;
      lcd_char_write = 1'b0;
      lcd_cursor_set = 1'b0;
      lcd_clear      = 1'b0;
      case (state)
         ST_IDLE: if (take) state_n = ST_ISSUE;
         ST_ISSUE: begin
            req_ready = onehot2(win_q);
            case (cmd_q)
               CMD_CHAR:   lcd_char_write = 1'b1;
               CMD_CURSOR: lcd_cursor_set = 1'b1;
               CMD_CLEAR:  lcd_clear      = 1'b1;
               default:    ;
            endcase
            state_n = (cmd_q == CMD_RSVD) ? ST_IDLE : ST_GUARD;
         end
         ST_GUARD: if (gcnt == 4'(GUARD_CYCLES - 1)) state_n = ST_WAIT_RDY;
         ST_WAIT_RDY: if (lcd_ready || timeout_hit) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   assign busy  = (state != ST_IDLE);
   assign grant = (state != ST_IDLE) ? onehot2(win_q) :
                  (lock_active ? onehot2(lock_owner) : 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         gcnt           <= 4'd0;
         cmd_q          <= CMD_CHAR;
         win_q          <= 1'b0;
         lcd_char       <= 8'd0;
         lcd_cursor_pos <= 5'd0;
         lock_vld       <= 1'b0;
         lock_owner     <= 1'b0;
      end else begin
         state <= state_n;
         gcnt  <= (state == ST_GUARD) ? gcnt + 4'd1 : 4'd0;
         if (take) begin
            cmd_q      <= cmd_w;
            win_q      <= win;
            lock_vld   <= req_lock[win];
            lock_owner <= win;
            if (cmd_w == CMD_CHAR)   lcd_char       <= data_w;
            if (cmd_w == CMD_CURSOR) lcd_cursor_pos <= data_w[4:0];
         end else if ((state == ST_IDLE && !lock_active) || timeout_hit) begin
            lock_vld <= 1'b0;
         end
      end
   end

`ifdef LCD_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
   logic          error_q;

   assign timeout_hit = (state == ST_WAIT_RDY) && !lcd_ready &&
                        (tcnt == TW'(TIMEOUT_CYCLES - 1));
   assign error       = error_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt    <= '0;
         error_q <= 1'b0;
      end else begin
         tcnt <= (state == ST_WAIT_RDY && !lcd_ready) ? tcnt + 1'b1 : '0;
         if (timeout_hit) error_q <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_request_arbiter.sv
// tb/tb_lcd_request_arbiter.sv - directed self-checking bench for lcd_request_arbiter
module tb_lcd_request_arbiter;
   import lcd_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_ready, req_lock, grant;
   logic [3:0]  req_cmd;
   logic [15:0] req_data;
   logic [7:0]  lcd_char;
   logic [4:0]  lcd_cursor_pos;
   logic        lcd_char_write, lcd_cursor_set, lcd_clear, lcd_ready, busy, error;

   int total = 0;
   int bad   = 0;

   lcd_request_arbiter #(.GUARD_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_lock(req_lock), .req_cmd(req_cmd), .req_data(req_data),
      .lcd_char(lcd_char), .lcd_char_write(lcd_char_write),
      .lcd_cursor_pos(lcd_cursor_pos), .lcd_cursor_set(lcd_cursor_set),
      .lcd_clear(lcd_clear), .lcd_ready(lcd_ready), .grant(grant),
      .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 30) begin
         step();
         n++;
      end
      chk(tag, busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] c0 [3];
      logic [7:0] d0 [3];
      logic [7:0] s_val [8];
      logic [1:0] s_gnt [8];
      logic [1:0] s_kind [8];
      int         s_t [8];
      int         ns, k, nstrobe;
      bit         done, hold_ok, seen;

      rst = 1'b1; req_valid = 0; req_lock = 0; req_cmd = 0; req_data = 0; lcd_ready = 1'b1;
      step(); step();
      chk("rst_outputs", {req_ready, lcd_char, lcd_char_write, lcd_cursor_pos,
                          lcd_cursor_set, lcd_clear, grant, busy, error}, 0);
      rst = 1'b0;

      // single CHAR from requester 0
      req_cmd[1:0] = CMD_CHAR; req_data[7:0] = 8'h41; req_valid = 2'b01;
      step();
      chk("t1_ready", req_ready, 2'b01);
      chk("t1_write", lcd_char_write, 1);
      chk("t1_char", lcd_char, 8'h41);
      chk("t1_grant", grant, 2'b01);
      req_valid = 2'b00;
      k = 1;
      while (k < 20) begin
         step();
         if (!busy) break;
         k++;
      end
      chk("t1_busy_cycles", k, 4);
      chk("t1_char_held", lcd_char, 8'h41);

      // alternation from a fresh reset
      rst = 1'b1; step(); rst = 1'b0;
      req_cmd = 4'h0; req_data = 16'h5830; req_valid = 2'b11;
      ns = 0;
      for (int cyc = 1; cyc <= 60 && ns < 4; cyc++) begin
         step();
         if (lcd_char_write) begin
            s_val[ns] = lcd_char; s_gnt[ns] = grant; s_t[ns] = cyc; ns++;
         end
      end
      req_valid = 2'b00;
      chk("t2_count", ns, 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_char%0d", i), s_val[i], (i % 2) ? 8'h58 : 8'h30);
         chk($sformatf("t2_grant%0d", i), s_gnt[i], (i % 2) ? 2'b10 : 2'b01);
      end
      chk("t2_spacing", s_t[3] - s_t[2], 5);
      wait_idle("t2_idle");

      // locked burst from requester 0 while requester 1 waits
      c0[0] = CMD_CLEAR;  d0[0] = 8'h00;
      c0[1] = CMD_CURSOR; d0[1] = {3'b000, LCD_LINE2_POS};
      c0[2] = CMD_CHAR;   d0[2] = 8'h50;
      req_cmd = {CMD_CHAR, c0[0]}; req_data = {8'h58, d0[0]};
      req_lock = 2'b01; req_valid = 2'b11;
      ns = 0; k = 0; done = 0; hold_ok = 1;
      for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
         step();
         if ((lcd_clear || lcd_cursor_set || lcd_char_write) && ns < 8) begin
            s_kind[ns] = lcd_clear ? 2'd2 : (lcd_cursor_set ? 2'd1 : 2'd0);
            s_val[ns]  = lcd_cursor_set ? {3'b000, lcd_cursor_pos} : lcd_char;
            s_gnt[ns]  = grant; s_t[ns] = cyc; ns++;
         end
         if (k < 3 && grant !== 2'b01) hold_ok = 0;
         if (req_ready[0]) begin
            k++;
            if (k < 3) begin
               req_cmd[1:0] = c0[k]; req_data[7:0] = d0[k];
            end else begin
               req_valid[0] = 1'b0; req_lock[0] = 1'b0;
            end
         end
         if (req_ready[1]) begin
            req_valid[1] = 1'b0; done = 1;
         end
      end
      chk("t3_count", ns, 4);
      chk("t3_lock_grant_held", hold_ok, 1);
      chk("t3_ev0_clear", s_kind[0], 2);
      chk("t3_ev1_cursor", {s_kind[1], s_val[1]}, {2'd1, 8'd16});
      chk("t3_ev2_char", {s_kind[2], s_val[2], s_gnt[2]}, {2'd0, 8'h50, 2'b01});
      chk("t3_ev3_req1", {s_kind[3], s_val[3], s_gnt[3]}, {2'd0, 8'h58, 2'b10});
      chk("t3_req1_first_idle", s_t[3] - s_t[2], 5);
      wait_idle("t3_idle");

      // lcd_ready held low after a strobe
      req_cmd = 4'h0; req_data = 16'h0011; req_valid = 2'b01;
      seen = 0;
      for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
         step();
         seen = req_ready[0];
      end
      chk("t4_first_issue", {seen, lcd_char}, {1'b1, 8'h11});
      lcd_ready = 1'b0; req_data[7:0] = 8'h22;
      nstrobe = 0;
      repeat (50) begin
         step();
         if (lcd_char_write || lcd_cursor_set || lcd_clear || req_ready != 0) nstrobe++;
      end
      chk("t4_no_strobes", nstrobe, 0);
      chk("t4_busy_wait", busy, 1);
      lcd_ready = 1'b1;
      step();
      chk("t4_idle_no_strobe", lcd_char_write, 0);
      step();
      chk("t4_next_issue", {lcd_char_write, lcd_char}, {1'b1, 8'h22});
      req_valid = 2'b00;
      wait_idle("t4_idle");

      // reserved command code
      req_cmd[1:0] = CMD_RSVD; req_valid = 2'b01;
      step();
      chk("t5_ready", req_ready, 2'b01);
      chk("t5_no_strobe", {lcd_char_write, lcd_cursor_set, lcd_clear}, 0);
      req_valid = 2'b00;
      step();
      chk("t5_back_idle", busy, 0);
      chk("t5_char_kept", lcd_char, 8'h22);

      // no grant while lcd_ready is low in IDLE
      lcd_ready = 1'b0; req_cmd = 4'h0; req_data = 16'h7700; req_valid = 2'b10;
      seen = 0;
      repeat (5) begin
         step();
         if (busy || grant != 0 || req_ready != 0) seen = 1;
      end
      chk("t6_no_grant", seen, 0);
      lcd_ready = 1'b1;
      step();
      chk("t6_grant_now", {req_ready, grant, lcd_char}, {2'b10, 2'b10, 8'h77});
      req_valid = 2'b00;
      wait_idle("t6_idle");

      // reset asserted in GUARD
      req_cmd = {CMD_CURSOR, 2'b00}; req_data = 16'h0500; req_lock = 2'b10; req_valid = 2'b10;
      step();
      chk("t7_cursor", {lcd_cursor_set, lcd_cursor_pos}, {1'b1, 5'd5});
      req_valid = 2'b00;
      step();
      chk("t7_in_guard", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("t7_async_rst", {req_ready, lcd_char, lcd_char_write, lcd_cursor_pos,
                           lcd_cursor_set, lcd_clear, grant, busy, error}, 0);
      req_lock = 2'b00;
      step();
      rst = 1'b0;

`ifdef LCD_ARB_TIMEOUT_EN
      req_cmd = 4'h0; req_data = 16'h0033; req_lock = 2'b01; req_valid = 2'b01;
      step();
      chk("t8_issue", req_ready, 2'b01);
      req_valid = 2'b00; lcd_ready = 1'b0;
      step(); step(); step();
      repeat (63) step();
      chk("t8_before", {error, busy}, {1'b0, 1'b1});
      step();
      chk("t8_error", error, 1);
      chk("t8_grant", grant, 2'b00);
      chk("t8_idle", busy, 0);
      req_lock = 2'b00; lcd_ready = 1'b1;
      step();
      chk("t8_sticky", error, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
